// File: rtl/mmio_arbiter.sv
// mmio_arbiter: NREQ-way arbiter in front of a single MMIO peripheral port.
// One transaction in flight, sequenced IDLE -> ISSUE -> RESP.
// Build option: define MMIO_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// otherwise arbitration is round-robin from a rotating pointer.
module mmio_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_wen,
    input  logic [NREQ-1:0][7:0]  req_addr,
    input  logic [NREQ-1:0][31:0] req_wdata,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  o_mmio_enable,
    output logic                  o_mmio_wen,
    output logic [7:0]            o_mmio_addr,
    output logic [31:0]           o_mmio_data_in,
    input  logic [31:0]           i_mmio_data_out
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] owner;
    logic [IW-1:0] winner;
    logic          found;

`ifdef MMIO_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-index valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] ptr;

    // Round-robin: scan requesters starting at ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    // Pointer moves past the owner when its response is delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (state == RESP) begin
            ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, accept strobe and response; everything is held low during reset.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_rdata  = '0;
        unique case (state)
            IDLE: begin
                if (found && !reset) begin
                    req_ready[winner] = 1'b1;
                    state_next        = ISSUE;
                end
            end
            ISSUE: state_next = RESP;
            RESP: begin
                state_next = IDLE;
                if (!reset) begin
                    rsp_valid[owner] = 1'b1;
                    rsp_rdata        = o_mmio_wen ? '0 : i_mmio_data_out;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the winning command on accept; the peripheral strobe is high only during ISSUE
    // and the command fields (which also serve as the latched command) hold afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_mmio_enable  <= 1'b0;
            o_mmio_wen     <= 1'b0;
            o_mmio_addr    <= '0;
            o_mmio_data_in <= '0;
            owner          <= '0;
        end else begin
            o_mmio_enable <= 1'b0;
            if (state == IDLE && found) begin
                o_mmio_enable  <= 1'b1;
                o_mmio_wen     <= req_wen[winner];
                o_mmio_addr    <= req_addr[winner];
                o_mmio_data_in <= req_wdata[winner];
                owner          <= winner;
            end
        end
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: transaction-level reference model of mmio_arbiter with a
// behavioural peripheral; directed all-valid phase then randomized traffic and resets.
// Honours MMIO_ARB_FIXED_PRIO_EN the same way as the design.
module tb_mmio_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_wen;
    logic [N-1:0][7:0] req_addr;
    logic [N-1:0][31:0] req_wdata;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              o_mmio_enable;
    logic              o_mmio_wen;
    logic [7:0]        o_mmio_addr;
    logic [31:0]       o_mmio_data_in;
    logic [31:0]       i_mmio_data_out;

    logic [31:0] periph_mem [256] = '{default: '0};
    logic [31:0] ref_mem    [256] = '{default: '0};

    int tests = 0;
    int fails = 0;

    // Model state: cycle numbers at which events are due.
    int          cyc = 0;
    int          free_at = 0;
    int          en_cyc = -1;
    int          rsp_cyc = -1;
    int          ptr = 0;
    int          owner = 0;
    logic [31:0] exp_rdata = '0;
    logic        hold_wen = 1'b0;
    logic [7:0]  hold_addr = '0;
    logic [31:0] hold_data = '0;
    logic [N-1:0] exp_ready;
    bit          all_on = 1'b0;
    bit          force_rst = 1'b1;
    bit          rand_rst = 1'b0;

    mmio_arbiter #(.NREQ(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_wen        (req_wen),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .o_mmio_enable  (o_mmio_enable),
        .o_mmio_wen     (o_mmio_wen),
        .o_mmio_addr    (o_mmio_addr),
        .o_mmio_data_in (o_mmio_data_in),
        .i_mmio_data_out(i_mmio_data_out)
    );

    always #5 clk = ~clk;

    // Peripheral: registered read data one cycle after enable, garbage otherwise.
    always @(posedge clk) begin
        if (o_mmio_enable && o_mmio_wen) periph_mem[o_mmio_addr] <= o_mmio_data_in;
        if (o_mmio_enable && !o_mmio_wen) i_mmio_data_out <= periph_mem[o_mmio_addr];
        else i_mmio_data_out <= $urandom;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic new_cmd(input int i);
        req_valid[i] = 1'b1;
        req_wen[i]   = 1'($urandom_range(1));
        req_addr[i]  = 8'($urandom_range(7));
        req_wdata[i] = $urandom;
    endtask

    task automatic step();
        int  w;
        bit  got;
        @(negedge clk);
        exp_ready = '0;
        w   = 0;
        got = 1'b0;
        if (!reset && cyc >= free_at && req_valid != '0) begin
            for (int k = 0; k < N; k++) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
                if (!got && req_valid[k]) begin got = 1'b1; w = k; end
`else
                if (!got && req_valid[(ptr + k) % N]) begin got = 1'b1; w = (ptr + k) % N; end
`endif
            end
            exp_ready[w] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("mmio_enable", 32'(o_mmio_enable), 32'(cyc == en_cyc));
        check("mmio_wen", 32'(o_mmio_wen), 32'(hold_wen));
        check("mmio_addr", 32'(o_mmio_addr), 32'(hold_addr));
        check("mmio_data_in", o_mmio_data_in, hold_data);
        if (cyc == rsp_cyc && !reset) begin
            check("rsp_valid", 32'(rsp_valid), 32'(1) << owner);
            check("rsp_rdata", rsp_rdata, exp_rdata);
        end else begin
            check("rsp_valid_idle", 32'(rsp_valid), 32'(0));
        end
        if (got) begin
            owner     = w;
            en_cyc    = cyc + 1;
            rsp_cyc   = cyc + 2;
            free_at   = cyc + 3;
            ptr       = (w + 1) % N;
            hold_wen  = req_wen[w];
            hold_addr = req_addr[w];
            hold_data = req_wdata[w];
            exp_rdata = req_wen[w] ? 32'(0) : ref_mem[req_addr[w]];
            if (req_wen[w]) ref_mem[req_addr[w]] = req_wdata[w];
        end
        if (reset) begin
            en_cyc    = -1;
            rsp_cyc   = -1;
            free_at   = cyc + 1;
            ptr       = 0;
            hold_wen  = 1'b0;
            hold_addr = '0;
            hold_data = '0;
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i]) begin
                if (all_on || $urandom_range(1) == 1) new_cmd(i);
                else req_valid[i] = 1'b0;
            end else if (!req_valid[i] && !all_on && $urandom_range(2) == 0) begin
                new_cmd(i);
            end
        end
        reset = force_rst || (rand_rst && $urandom_range(40) == 0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_wdata = '0;
        @(posedge clk);
        #1;
        step();
        step();
        // All requesters valid continuously out of reset.
        force_rst = 1'b0;
        all_on    = 1'b1;
        step();
        for (int i = 0; i < N; i++) new_cmd(i);
        repeat (16) step();
        // Reset pulse, then randomized traffic with sporadic resets.
        all_on    = 1'b0;
        force_rst = 1'b1;
        step();
        force_rst = 1'b0;
        rand_rst  = 1'b1;
        repeat (3000) step();
        rand_rst = 1'b0;
        reset    = 1'b0;
        repeat (6) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_arbiter.md
MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (legal range 2..8).
REQ-002 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 req_valid  input  NREQ  SHALL be the per-requester command-valid flags.
REQ-005 req_wen  input  NREQ  SHALL be the per-requester write enable (1 = write, 0 = read).
REQ-006 req_addr  input  NREQ x 8  SHALL be the per-requester MMIO address.
REQ-007 req_wdata  input  NREQ x 32  SHALL be the per-requester write data.
REQ-008 req_ready  output  NREQ  SHALL be the per-requester accept strobe.
REQ-009 rsp_valid  output  NREQ  SHALL be the per-requester completion pulse.
REQ-010 rsp_rdata  output  32  SHALL be the read data, shared and qualified by rsp_valid.
REQ-011 o_mmio_enable, o_mmio_wen  output  1 each  SHALL be the peripheral strobe and write select.
REQ-012 o_mmio_addr  output  8 ; o_mmio_data_in  output  32  SHALL be the peripheral address and write data.
REQ-013 i_mmio_data_out  input  32  SHALL be the peripheral registered read data, valid one cycle after the enable cycle.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE and RESP; there SHALL be exactly one transaction in flight.
REQ-015 IDLE: if any req_valid is set, the arbiter SHALL pick one winner, assert req_ready[winner] combinationally that cycle, latch wen/addr/wdata/owner, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-016 req_ready SHALL be one-hot or zero, and SHALL be zero outside IDLE.
REQ-017 ISSUE: the block SHALL drive registered o_mmio_enable=1 with the latched command for exactly one cycle, then go to RESP.
REQ-018 RESP: the block SHALL pulse rsp_valid[owner] for one cycle; rsp_rdata SHALL equal i_mmio_data_out for reads and 0 for writes; it SHALL then return to IDLE.
REQ-019 Outside ISSUE, o_mmio_enable SHALL be 0 and o_mmio_wen/addr/data_in SHALL hold their last values.
REQ-020 Default arbitration SHALL be round-robin: search starts at pointer P; in RESP, P becomes (owner+1) mod NREQ, wrapping NREQ-1 to 0.
REQ-021 A req_valid deassertion after acceptance SHALL NOT affect the in-flight transaction; valid without ready SHALL leave the command pending.
REQ-022 Sustained throughput SHALL be one transaction per 3 cycles; accept-to-rsp_valid latency SHALL be 2 cycles.

Reset
REQ-023 Reset SHALL force state=IDLE, P=0, and all of the following to 0: o_mmio_enable, o_mmio_wen, o_mmio_addr, o_mmio_data_in, rsp_valid, rsp_rdata.
REQ-024 Reset asserted in ISSUE or RESP SHALL abort the transaction with no rsp_valid pulse; req_ready SHALL be 0 while reset is high.

Configuration
REQ-025 With macro MMIO_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, lowest index wins, and P SHALL be unused.
REQ-026 Without MMIO_ARB_FIXED_PRIO_EN, round-robin per REQ-020 SHALL apply.

Verification
REQ-027 Single read: req0 reads addr 0x01, peripheral returns 0x0000_A5A5 -> o_mmio_enable 1 cycle after accept, then rsp_valid[0] with rsp_rdata=0x0000_A5A5.
REQ-028 Single write: req2 writes 0x0000_00FF to 0x01 -> one enable cycle with wen=1, addr=0x01, data_in=0xFF, then rsp_valid[2] with rsp_rdata=0.
REQ-029 All four requesters valid continuously from reset (round-robin) -> grants 0,1,2,3,0, spaced 3 cycles apart.
REQ-030 Same stimulus with MMIO_ARB_FIXED_PRIO_EN -> req0 granted every transaction until it drops valid, then req1.
REQ-031 Reset pulsed during ISSUE of req1 read -> no rsp_valid, all outputs 0, next grant goes to req0.
REQ-032 req3 drops valid 1 cycle after accept -> its transaction still completes with rsp_valid[3].
